// File: rtl/nabp_image_writer_pkg.sv
// Shared widths, writer state encoding and small helpers
// for the NABP image writer stream stage.
package nabp_image_writer_pkg;

    localparam int kImageAddressLength = 14;
    localparam int kFilteredDataLength = 16;
    localparam int kSkipCountLength    = 16;

    typedef enum logic [1:0] {
        idle_s   = 2'd0,
        active_s = 2'd1,
        drain_s  = 2'd2
    } image_writer_state_e;

    function automatic logic [kSkipCountLength-1:0] sat_inc(
        input logic [kSkipCountLength-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nabp_image_writer_fifo.sv
// Synchronous first-word-fall-through FIFO, power-of-two depth.
// Pushes when full and pops when empty are ignored.
module nabp_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] kFull = DEPTH[AW:0];
    localparam logic [AW:0] kOne  = 1;
    localparam logic [AW-1:0] kPtrOne = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == kFull);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + kPtrOne;
            if (do_pop)  rd_q <= rd_q + kPtrOne;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + kOne;
                2'b01:   cnt_q <= cnt_q - kOne;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; only entries behind the count are read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/nabp_image_writer.sv
// Pairs buffered PE-chain pixels with addresser addresses and
// issues image RAM writes, skipping out-of-range pixels.
module nabp_image_writer
    import nabp_image_writer_pkg::*;
#(
    parameter int DATA_WIDTH = kFilteredDataLength,
    parameter int ADDR_WIDTH = kImageAddressLength,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ir_kick,
    input  logic                        ir_done,
    input  logic                        ir_addr_valid,
    input  logic [ADDR_WIDTH-1:0]       ir_addr,
    output logic                        ir_enable,
    input  logic [DATA_WIDTH-1:0]       pe_data,
    input  logic                        pe_valid,
    output logic                        pe_ready,
    input  logic                        ram_ready,
    output logic                        ram_we,
    output logic [ADDR_WIDTH-1:0]       ram_waddr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    output logic                        hs_done,
    output logic                        busy,
    output logic [kSkipCountLength-1:0] skip_count
);

    image_writer_state_e         state_q;
    logic                        ram_we_q;
    logic [ADDR_WIDTH-1:0]       ram_waddr_q;
    logic [DATA_WIDTH-1:0]       ram_wdata_q;
    logic                        hs_done_q;
    logic [kSkipCountLength-1:0] skip_q;

    logic                  full;
    logic                  empty;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] head;

    assign pe_ready  = !full;
    assign pop_ok    = (state_q == active_s) && !empty && ram_ready;
    assign ir_enable = pop_ok;

    nabp_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (pe_valid),
        .pop     (pop_ok),
        .din     (pe_data),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= idle_s;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            hs_done_q   <= 1'b0;
            skip_q      <= '0;
        end else begin
            ram_we_q  <= 1'b0;
            hs_done_q <= 1'b0;
            if (pop_ok) begin
                ram_we_q    <= ir_addr_valid;
                ram_waddr_q <= ir_addr;
                ram_wdata_q <= head;
                if (!ir_addr_valid) skip_q <= sat_inc(skip_q);
            end
            unique case (state_q)
                idle_s: begin
                    if (ir_kick) begin
                        state_q <= active_s;
                        skip_q  <= '0;
                    end
                end
                active_s: begin
                    if (pop_ok && ir_done) begin
                        state_q   <= drain_s;
                        hs_done_q <= 1'b1;
                    end
                end
                drain_s: state_q <= idle_s;
                default: state_q <= idle_s;
            endcase
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_waddr  = ram_waddr_q;
    assign ram_wdata  = ram_wdata_q;
    assign hs_done    = hs_done_q;
    assign skip_count = skip_q;
    assign busy       = (state_q != idle_s);

endmodule
